// File: rtl/ped_request_scheduler.sv
// ped_request_scheduler
// Front end for the pedestrian light controller. Conditions the raw crossing
// buttons, latches each request until its walk cycle has been served, lets
// only one direction be armed at a time, and stretches the green-delay word
// of a direction that has a request waiting.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   btn_ns_raw, btn_ew_raw         raw push-buttons (asynchronous)
//   NS_RED, EW_RED                 vehicles stopped, from the base FSM
//   pd_FREE_x, pd_CAUTION_x        walk status, from the pedestrian controller
//   pd_button_ns, pd_button_ew     request level to the pedestrian controller
//   ns_green_delay, ew_green_delay green duration words
//   pending_ns, pending_ew         request latched and not yet served
//   force_ns, force_ew             starvation flags to the base FSM
//   wait_ns, wait_ew               unserved red phases (saturating)
module ped_request_scheduler #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int BASE_GREEN_CYCLES = 500,
  parameter int PED_EXTEND_CYCLES = 200,
  parameter int MAX_WAIT_PHASES   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ns_raw,
  input  logic        btn_ew_raw,
  input  logic        NS_RED,
  input  logic        EW_RED,
  input  logic        pd_FREE_NS,
  input  logic        pd_CAUTION_NS,
  input  logic        pd_FREE_EW,
  input  logic        pd_CAUTION_EW,
  output logic        pd_button_ns,
  output logic        pd_button_ew,
  output logic [31:0] ns_green_delay,
  output logic [31:0] ew_green_delay,
  output logic        pending_ns,
  output logic        pending_ew,
  output logic        force_ns,
  output logic        force_ew,
  output logic [7:0]  wait_ns,
  output logic [7:0]  wait_ew
);

  localparam int          CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [31:0] DELAY_IDLE = 32'(BASE_GREEN_CYCLES);
  localparam logic [31:0] DELAY_PEND = 32'(BASE_GREEN_CYCLES + PED_EXTEND_CYCLES);

  typedef enum logic [1:0] {IDLE, PENDING, ARMED, SERVING} state_t;

  // Index 0 is NS, index 1 is EW throughout.
  logic [1:0]       btn_raw, red, free, caution;
  logic [1:0]       sync_p0, sync_p1, press_p2;
  logic [CNT_W-1:0] deb_cnt [2];

  state_t           state [2];
  logic [1:0]       rep, seen_free, red_q, pd_btn;
  logic [1:0]       pending_v, force_req, elig, busy, grant;
  logic [7:0]       wait_cnt [2];
  logic [31:0]      delay_q [2];
  logic             ptr, ptr_toggle;

  assign btn_raw = {btn_ew_raw, btn_ns_raw};
  assign red     = {EW_RED, NS_RED};
  assign free    = {pd_FREE_EW, pd_FREE_NS};
  assign caution = {pd_CAUTION_EW, pd_CAUTION_NS};

  // Stage p0/p1: two-flop synchroniser. Stage p2: debounce counter and a
  // one-cycle press pulse on the cycle the counter first hits its target;
  // saturation keeps a held button from producing further pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      press_p2 <= '0;
      for (int d = 0; d < 2; d++) deb_cnt[d] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int d = 0; d < 2; d++) begin
        if (!sync_p1[d])
          deb_cnt[d] <= '0;
        else if (deb_cnt[d] != CNT_W'(DEBOUNCE_CYCLES))
          deb_cnt[d] <= deb_cnt[d] + CNT_W'(1);
        press_p2[d] <= sync_p1[d] && (deb_cnt[d] == CNT_W'(DEBOUNCE_CYCLES - 1));
      end
    end
  end

  // Arbiter: nothing is granted while either side is armed or walking. On a
  // tie a lone starving direction wins without moving the pointer; otherwise
  // the pointer decides and then passes to the other side.
  always_comb begin
    elig       = '0;
    busy       = '0;
    pending_v  = '0;
    force_req  = '0;
    grant      = '0;
    ptr_toggle = 1'b0;
    for (int d = 0; d < 2; d++) begin
      elig[d]      = (state[d] == PENDING) && red[d];
      busy[d]      = (state[d] == ARMED) || (state[d] == SERVING);
      pending_v[d] = (state[d] == PENDING) || (state[d] == ARMED);
      force_req[d] = wait_cnt[d] >= 8'(MAX_WAIT_PHASES);
    end
    if (busy == 2'b00) begin
      if (elig == 2'b11) begin
        if (force_req[0] != force_req[1]) begin
          grant = force_req;
        end else begin
          grant[ptr] = 1'b1;
          ptr_toggle = 1'b1;
        end
      end else begin
        grant = elig;
      end
    end
  end

  // Request FSMs, starvation counters and green-delay words.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        state[d]     <= IDLE;
        rep[d]       <= 1'b0;
        seen_free[d] <= 1'b0;
        red_q[d]     <= 1'b0;
        pd_btn[d]    <= 1'b0;
        wait_cnt[d]  <= '0;
        delay_q[d]   <= DELAY_IDLE;
      end
    end else begin
      ptr <= ptr ^ ptr_toggle;
      for (int d = 0; d < 2; d++) begin
        red_q[d] <= red[d];
        // Delay is frozen once armed so the walk window cannot shift mid-cycle.
        if ((state[d] == IDLE) || (state[d] == PENDING))
          delay_q[d] <= (state[d] == PENDING) ? DELAY_PEND : DELAY_IDLE;
        if (red[d] && !red_q[d] && pending_v[d] && (wait_cnt[d] != 8'hFF))
          wait_cnt[d] <= wait_cnt[d] + 8'd1;
        case (state[d])
          IDLE: begin
            if (press_p2[d]) state[d] <= PENDING;
          end
          PENDING: begin
            if (grant[d]) begin
              state[d]  <= ARMED;
              pd_btn[d] <= 1'b1;
            end
          end
          ARMED: begin
            // A falling RED beats a simultaneous FREE.
            if (!red[d]) begin
              state[d]  <= PENDING;
              pd_btn[d] <= 1'b0;
            end else if (free[d]) begin
              state[d]     <= SERVING;
              pd_btn[d]    <= 1'b0;
              seen_free[d] <= 1'b1;
              wait_cnt[d]  <= '0;
            end
          end
          SERVING: begin
            if (free[d]) seen_free[d] <= 1'b1;
            if (!red[d] || (!free[d] && !caution[d] && seen_free[d])) begin
              state[d]     <= (rep[d] || press_p2[d]) ? PENDING : IDLE;
              rep[d]       <= 1'b0;
              seen_free[d] <= 1'b0;
            end else if (press_p2[d]) begin
              rep[d] <= 1'b1;
            end
          end
          default: state[d] <= IDLE;
        endcase
      end
    end
  end

  assign pd_button_ns   = pd_btn[0];
  assign pd_button_ew   = pd_btn[1];
  assign pending_ns     = pending_v[0];
  assign pending_ew     = pending_v[1];
  assign force_ns       = force_req[0];
  assign force_ew       = force_req[1];
  assign wait_ns        = wait_cnt[0];
  assign wait_ew        = wait_cnt[1];
  assign ns_green_delay = delay_q[0];
  assign ew_green_delay = delay_q[1];

endmodule

// File: tb/tb_ped_request_scheduler.sv
// Testbench for ped_request_scheduler: directed scenarios with expected values
// taken from the behaviour description, plus randomized traffic checked
// against a behavioural reference model kept in this file.
module tb_ped_request_scheduler;

  localparam int D    = 4;
  localparam int BASE = 100;
  localparam int EXT  = 40;
  localparam int MAXW = 2;

  localparam int S_IDLE = 0, S_PEND = 1, S_ARM = 2, S_SERV = 3;

  logic        clk = 1'b0;
  logic        rst, btn_ns_raw, btn_ew_raw, NS_RED, EW_RED;
  logic        pd_FREE_NS, pd_CAUTION_NS, pd_FREE_EW, pd_CAUTION_EW;
  logic        pd_button_ns, pd_button_ew, pending_ns, pending_ew, force_ns, force_ew;
  logic [31:0] ns_green_delay, ew_green_delay;
  logic [7:0]  wait_ns, wait_ew;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_st [2];
  bit m_rep [2];
  int m_wait [2];
  int m_delay [2];
  bit m_ptr;
  bit m_redq [2];
  bit hist [2][D+3];  // hist[d][i] = raw level sampled i+1 edges ago

  ped_request_scheduler #(
    .DEBOUNCE_CYCLES(D), .BASE_GREEN_CYCLES(BASE),
    .PED_EXTEND_CYCLES(EXT), .MAX_WAIT_PHASES(MAXW)
  ) dut (
    .clk(clk), .rst(rst), .btn_ns_raw(btn_ns_raw), .btn_ew_raw(btn_ew_raw),
    .NS_RED(NS_RED), .EW_RED(EW_RED),
    .pd_FREE_NS(pd_FREE_NS), .pd_CAUTION_NS(pd_CAUTION_NS),
    .pd_FREE_EW(pd_FREE_EW), .pd_CAUTION_EW(pd_CAUTION_EW),
    .pd_button_ns(pd_button_ns), .pd_button_ew(pd_button_ew),
    .ns_green_delay(ns_green_delay), .ew_green_delay(ew_green_delay),
    .pending_ns(pending_ns), .pending_ew(pending_ew),
    .force_ns(force_ns), .force_ew(force_ew),
    .wait_ns(wait_ns), .wait_ew(wait_ew)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the current inputs, then let the DUT
  // take the same edge and return on the following falling edge.
  task automatic step();
    bit raw [2], red [2], fr [2], ca [2];
    bit press [2], elig [2], grant [2], fc [2];
    bit busy;
    raw = '{btn_ns_raw, btn_ew_raw};
    red = '{NS_RED, EW_RED};
    fr  = '{pd_FREE_NS, pd_FREE_EW};
    ca  = '{pd_CAUTION_NS, pd_CAUTION_EW};
    if (rst) begin
      m_ptr = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_st[d] = S_IDLE; m_rep[d] = 1'b0; m_wait[d] = 0;
        m_delay[d] = BASE; m_redq[d] = 1'b0;
        for (int i = 0; i < D + 3; i++) hist[d][i] = 1'b0;
      end
    end else begin
      busy = 1'b0;
      for (int d = 0; d < 2; d++) begin
        // A press acts when exactly D consecutive high samples end three edges ago.
        press[d] = !hist[d][D+2];
        for (int i = 2; i <= D + 1; i++) if (!hist[d][i]) press[d] = 1'b0;
        elig[d]  = (m_st[d] == S_PEND) && red[d];
        fc[d]    = m_wait[d] >= MAXW;
        grant[d] = 1'b0;
        if (m_st[d] == S_ARM || m_st[d] == S_SERV) busy = 1'b1;
      end
      if (!busy) begin
        if (elig[0] && elig[1]) begin
          if (fc[0] && !fc[1]) grant[0] = 1'b1;
          else if (fc[1] && !fc[0]) grant[1] = 1'b1;
          else begin grant[m_ptr] = 1'b1; m_ptr = !m_ptr; end
        end else begin
          grant[0] = elig[0]; grant[1] = elig[1];
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (m_st[d] == S_IDLE) m_delay[d] = BASE;
        if (m_st[d] == S_PEND) m_delay[d] = BASE + EXT;
        if (red[d] && !m_redq[d] && (m_st[d] == S_PEND || m_st[d] == S_ARM) && m_wait[d] < 255)
          m_wait[d]++;
        m_redq[d] = red[d];
        case (m_st[d])
          S_IDLE: if (press[d]) m_st[d] = S_PEND;
          S_PEND: if (grant[d]) m_st[d] = S_ARM;
          S_ARM: begin
            if (!red[d]) m_st[d] = S_PEND;
            else if (fr[d]) begin m_st[d] = S_SERV; m_wait[d] = 0; end
          end
          default: begin
            if (!red[d] || (!fr[d] && !ca[d])) begin
              m_st[d] = (m_rep[d] || press[d]) ? S_PEND : S_IDLE;
              m_rep[d] = 1'b0;
            end else if (press[d]) m_rep[d] = 1'b1;
          end
        endcase
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = D + 2; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = rst ? 1'b0 : raw[d];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    btn_ns_raw = 0; btn_ew_raw = 0; NS_RED = 0; EW_RED = 0;
    pd_FREE_NS = 0; pd_CAUTION_NS = 0; pd_FREE_EW = 0; pd_CAUTION_EW = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; step(); rst = 0;
  endtask

  task automatic press_buttons(input bit ns, input bit ew);
    btn_ns_raw = ns; btn_ew_raw = ew;
    repeat (8) step();
    btn_ns_raw = 0; btn_ew_raw = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; step(); step(); rst = 0;
    checks++; if ({pending_ns, pending_ew, pd_button_ns, pd_button_ew, force_ns, force_ew} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {pending_ns, pending_ew, pd_button_ns, pd_button_ew, force_ns, force_ew}); end
    checks++; if (wait_ns !== 8'd0) begin errors++; $display("FAIL reset_wait_ns: got %0d expected 0", wait_ns); end
    checks++; if (wait_ew !== 8'd0) begin errors++; $display("FAIL reset_wait_ew: got %0d expected 0", wait_ew); end
    checks++; if (ns_green_delay !== 32'(BASE)) begin errors++; $display("FAIL reset_ns_delay: got %0d expected %0d", ns_green_delay, BASE); end
    checks++; if (ew_green_delay !== 32'(BASE)) begin errors++; $display("FAIL reset_ew_delay: got %0d expected %0d", ew_green_delay, BASE); end
  endtask

  task automatic test_press_latency();
    do_reset();
    btn_ns_raw = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (pending_ns !== (k >= D + 3)) begin errors++; $display("FAIL press_pending_edge%0d: got %b expected %b", k, pending_ns, k >= D + 3); end
      checks++; if (pd_button_ns !== 1'b0) begin errors++; $display("FAIL press_pd_button_edge%0d: got %b expected 0", k, pd_button_ns); end
      if (k == 7) begin
        checks++; if (ns_green_delay !== 32'(BASE)) begin errors++; $display("FAIL press_delay_edge7: got %0d expected %0d", ns_green_delay, BASE); end
      end
      if (k == 8) begin
        checks++; if (ns_green_delay !== 32'(BASE + EXT)) begin errors++; $display("FAIL press_delay_edge8: got %0d expected %0d", ns_green_delay, BASE + EXT); end
      end
    end
    // Button still held through a full service: no second request may appear.
    NS_RED = 1; step();
    checks++; if (pd_button_ns !== 1'b1) begin errors++; $display("FAIL held_armed: got %b expected 1", pd_button_ns); end
    pd_FREE_NS = 1; step();
    pd_FREE_NS = 0; step(); step(); step();
    checks++; if (pending_ns !== 1'b0) begin errors++; $display("FAIL held_single_event: got %b expected 0", pending_ns); end
    checks++; if (ns_green_delay !== 32'(BASE)) begin errors++; $display("FAIL held_delay_back: got %0d expected %0d", ns_green_delay, BASE); end
    btn_ns_raw = 0;
  endtask

  task automatic test_glitch();
    do_reset();
    btn_ew_raw = 1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) btn_ew_raw = 0;
      step();
      checks++; if (pending_ew !== 1'b0) begin errors++; $display("FAIL glitch_pending_%0d: got %b expected 0", k, pending_ew); end
      checks++; if (ew_green_delay !== 32'(BASE)) begin errors++; $display("FAIL glitch_delay_%0d: got %0d expected %0d", k, ew_green_delay, BASE); end
    end
    // Exactly DEBOUNCE_CYCLES high samples is enough.
    btn_ew_raw = 1;
    for (int k = 1; k <= 9; k++) begin
      if (k == D + 1) btn_ew_raw = 0;
      step();
      checks++; if (pending_ew !== (k >= D + 3)) begin errors++; $display("FAIL min_press_%0d: got %b expected %b", k, pending_ew, k >= D + 3); end
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    press_buttons(1, 1);
    checks++; if ({pending_ns, pending_ew} !== 2'b11) begin errors++; $display("FAIL arb_both_pending: got %b expected 11", {pending_ns, pending_ew}); end
    NS_RED = 1; EW_RED = 1; step();
    checks++; if ({pd_button_ns, pd_button_ew} !== 2'b10) begin errors++; $display("FAIL arb_ns_first: got %b expected 10", {pd_button_ns, pd_button_ew}); end
    pd_FREE_NS = 1; step();
    checks++; if ({pending_ns, pd_button_ns, pd_button_ew} !== 3'b000) begin errors++; $display("FAIL arb_ns_serving: got %b expected 000", {pending_ns, pd_button_ns, pd_button_ew}); end
    pd_FREE_NS = 0; pd_CAUTION_NS = 1; step();
    checks++; if (pd_button_ew !== 1'b0) begin errors++; $display("FAIL arb_ew_blocked_caution: got %b expected 0", pd_button_ew); end
    pd_CAUTION_NS = 0; step();
    checks++; if (pd_button_ew !== 1'b0) begin errors++; $display("FAIL arb_ew_blocked_exit: got %b expected 0", pd_button_ew); end
    step();
    checks++; if (pd_button_ew !== 1'b1) begin errors++; $display("FAIL arb_ew_granted: got %b expected 1", pd_button_ew); end
    checks++; if (wait_ew !== 8'd1) begin errors++; $display("FAIL arb_wait_ew: got %0d expected 1", wait_ew); end
  endtask

  task automatic test_starvation();
    do_reset();
    press_buttons(1, 1);
    NS_RED = 1; EW_RED = 1; step();   // tie, pointer NS -> NS armed, pointer moves to EW
    NS_RED = 0; EW_RED = 0; step();
    checks++; if ({pending_ns, pd_button_ns} !== 2'b10) begin errors++; $display("FAIL starve_back_pending: got %b expected 10", {pending_ns, pd_button_ns}); end
    NS_RED = 1; step();
    checks++; if (wait_ns !== 8'd2) begin errors++; $display("FAIL starve_wait_ns: got %0d expected 2", wait_ns); end
    checks++; if ({force_ns, force_ew} !== 2'b10) begin errors++; $display("FAIL starve_force: got %b expected 10", {force_ns, force_ew}); end
    NS_RED = 0; step();
    NS_RED = 1; EW_RED = 1; step();
    checks++; if ({pd_button_ns, pd_button_ew} !== 2'b10) begin errors++; $display("FAIL starve_forced_grant: got %b expected 10", {pd_button_ns, pd_button_ew}); end
    pd_FREE_NS = 1; step();
    checks++; if (wait_ns !== 8'd0) begin errors++; $display("FAIL starve_wait_clear: got %0d expected 0", wait_ns); end
    checks++; if (force_ns !== 1'b0) begin errors++; $display("FAIL starve_force_clear: got %b expected 0", force_ns); end
    pd_FREE_NS = 0; step(); step();
    checks++; if (pd_button_ew !== 1'b1) begin errors++; $display("FAIL starve_ew_after: got %b expected 1", pd_button_ew); end
  endtask

  task automatic test_red_drop();
    do_reset();
    press_buttons(1, 0);
    NS_RED = 1; step();
    checks++; if (pd_button_ns !== 1'b1) begin errors++; $display("FAIL drop_armed: got %b expected 1", pd_button_ns); end
    NS_RED = 0; pd_FREE_NS = 1; step();
    checks++; if ({pending_ns, pd_button_ns} !== 2'b10) begin errors++; $display("FAIL drop_back_pending: got %b expected 10", {pending_ns, pd_button_ns}); end
    checks++; if (ns_green_delay !== 32'(BASE + EXT)) begin errors++; $display("FAIL drop_delay: got %0d expected %0d", ns_green_delay, BASE + EXT); end
    pd_FREE_NS = 0; step();
    checks++; if (ns_green_delay !== 32'(BASE + EXT)) begin errors++; $display("FAIL drop_delay_hold: got %0d expected %0d", ns_green_delay, BASE + EXT); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_buttons(1, 1);
    NS_RED = 1; EW_RED = 1; step();
    pd_FREE_NS = 1; step();
    checks++; if (pending_ns !== 1'b0 || pending_ew !== 1'b1) begin errors++; $display("FAIL mid_serving: got %b expected 01", {pending_ns, pending_ew}); end
    rst = 1; step(); rst = 0;
    checks++; if ({pending_ns, pending_ew, pd_button_ns, pd_button_ew, force_ns, force_ew} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 000000", {pending_ns, pending_ew, pd_button_ns, pd_button_ew, force_ns, force_ew}); end
    checks++; if ({wait_ns, wait_ew} !== 16'd0) begin errors++; $display("FAIL mid_reset_wait: got %0d/%0d expected 0/0", wait_ns, wait_ew); end
    checks++; if (ns_green_delay !== 32'(BASE) || ew_green_delay !== 32'(BASE)) begin
      errors++; $display("FAIL mid_reset_delay: got %0d/%0d expected %0d/%0d", ns_green_delay, ew_green_delay, BASE, BASE); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [5:0] exp_flags;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) btn_ns_raw = !btn_ns_raw;
      if ($urandom_range(0, 9) == 0) btn_ew_raw = !btn_ew_raw;
      if ($urandom_range(0, 14) == 0) NS_RED = !NS_RED;
      if ($urandom_range(0, 14) == 0) EW_RED = !EW_RED;
      if ($urandom_range(0, 3) == 0) pd_FREE_NS = !pd_FREE_NS;
      if ($urandom_range(0, 3) == 0) pd_CAUTION_NS = !pd_CAUTION_NS;
      if ($urandom_range(0, 3) == 0) pd_FREE_EW = !pd_FREE_EW;
      if ($urandom_range(0, 3) == 0) pd_CAUTION_EW = !pd_CAUTION_EW;
      rst = ($urandom_range(0, 499) == 0);
      step();
      exp_flags = {m_st[0] == S_PEND || m_st[0] == S_ARM, m_st[1] == S_PEND || m_st[1] == S_ARM,
                   m_st[0] == S_ARM, m_st[1] == S_ARM, m_wait[0] >= MAXW, m_wait[1] >= MAXW};
      checks++; if ({pending_ns, pending_ew, pd_button_ns, pd_button_ew, force_ns, force_ew} !== exp_flags) begin
        errors++; $display("FAIL rand_flags cycle %0d: got %b expected %b", n, {pending_ns, pending_ew, pd_button_ns, pd_button_ew, force_ns, force_ew}, exp_flags); end
      checks++; if (wait_ns !== 8'(m_wait[0])) begin errors++; $display("FAIL rand_wait_ns cycle %0d: got %0d expected %0d", n, wait_ns, m_wait[0]); end
      checks++; if (wait_ew !== 8'(m_wait[1])) begin errors++; $display("FAIL rand_wait_ew cycle %0d: got %0d expected %0d", n, wait_ew, m_wait[1]); end
      checks++; if (ns_green_delay !== 32'(m_delay[0])) begin errors++; $display("FAIL rand_ns_delay cycle %0d: got %0d expected %0d", n, ns_green_delay, m_delay[0]); end
      checks++; if (ew_green_delay !== 32'(m_delay[1])) begin errors++; $display("FAIL rand_ew_delay cycle %0d: got %0d expected %0d", n, ew_green_delay, m_delay[1]); end
    end
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_press_latency();
    test_glitch();
    test_arbitration();
    test_starvation();
    test_red_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
